trace_capture_fifo: RTL and testbench

- Sits directly downstream of the CDC bus stage, in the destination clock domain.
- Consumes the single-cycle word pulses the CDC stage produces and tags each word with a saturating inter-arrival cycle delta.
- Buffers tagged words in a first-word-fall-through FIFO for the register/readout interface.
- Reports drops, underflow and occupancy for host-side overflow diagnosis.

---
 rtl/trace_capture_fifo.sv | 132 +++++++++++++
 tb/tb_trace_capture_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo: tags each CDC word pulse with a saturating inter-arrival
// cycle delta and buffers {delta, data} in a first-word-fall-through FIFO.
// Occupancy is tracked in a count register, and full/empty are decoded from it.
// Drops, underflow and a saturating drop counter support host-side diagnosis.
module trace_capture_fifo #(
    parameter int pDATA_WIDTH = 8,
    parameter int pTS_WIDTH   = 16,
    parameter int pDEPTH      = 16,
    parameter int pDROP_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear_i,
    input  logic                             in_pulse,
    input  logic [pDATA_WIDTH-1:0]           in_data,
    input  logic                             rd_en,
    output logic [pTS_WIDTH+pDATA_WIDTH-1:0] rd_data,
    output logic                             empty,
    output logic                             full,
    output logic [$clog2(pDEPTH):0]          count,
    output logic                             overflow,
    output logic                             underflow,
    output logic [pDROP_WIDTH-1:0]           drop_count
);

    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;
    localparam int EW = pTS_WIDTH + pDATA_WIDTH;

    logic [EW-1:0]          mem_q [pDEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [pTS_WIDTH-1:0]   delta_q, delta_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic [pDROP_WIDTH-1:0] drop_q, drop_d;

    logic empty_w, full_w;
    logic wr_acc, rd_acc, drop_w, mem_we;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(pDEPTH));

    // A write while full is still accepted when the head is popped in the same
    // cycle; the tail slot equals the head slot then, and the head has already
    // been presented combinationally before the edge overwrites it.
    assign wr_acc = in_pulse && (!full_w || rd_en);
    assign rd_acc = rd_en && !empty_w;
    assign drop_w = in_pulse && full_w && !rd_en;
    assign mem_we = wr_acc && !clear_i;

    // Next-state for pointers, occupancy, delta timer and diagnostics.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        delta_d     = (delta_q == '1) ? delta_q : delta_q + 1'b1;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        drop_d      = drop_q;

        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            delta_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            drop_d      = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                delta_d  = pTS_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (rd_en && empty_w) begin
                underflow_d = 1'b1;
            end
            if (drop_w) begin
                overflow_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            delta_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            delta_q     <= delta_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_q      <= drop_d;
        end
    end

    // Storage array; contents need no reset because empty masks rd_data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {delta_q, in_data};
        end
    end

    assign rd_data    = empty_w ? '0 : mem_q[rd_ptr_q];
    assign empty      = empty_w;
    assign full       = full_w;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_capture_fifo.sv
module tb_trace_capture_fifo;

    logic        clk;
    logic        reset_n;
    logic        clear_i;
    logic        in_pulse;
    logic [7:0]  in_data;
    logic        rd_en;
    logic [23:0] rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;
    logic [7:0]  drop_count;

    int vectors;
    int miscompares;

    trace_capture_fifo #(
        .pDATA_WIDTH(8),
        .pTS_WIDTH  (16),
        .pDEPTH     (16),
        .pDROP_WIDTH(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (clear_i),
        .in_pulse  (in_pulse),
        .in_data   (in_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        in_pulse = 1'b1;
        in_data  = d;
        tick();
        in_pulse = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_status empty=%b full=%b count=%0d, want 1 0 0", empty, full, count);
        end
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || drop_count !== 8'd0 || rd_data !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_flags ovf=%b unf=%b drop=%0d rd=%h, want 0 0 0 000000",
                     overflow, underflow, drop_count, rd_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_first_word();
        // Delta counter starts at 0 and counts six idle edges before the write.
        repeat (6) tick();
        push(8'hA5);
        vectors++;
        if (empty !== 1'b0 || count !== 5'd1) begin
            miscompares++;
            $display("FAIL first_status empty=%b count=%0d, want 0 1", empty, count);
        end
        vectors++;
        if (rd_data !== {16'd6, 8'hA5}) begin
            miscompares++;
            $display("FAIL first_data got %h want %h", rd_data, {16'd6, 8'hA5});
        end
        pop();
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0 || rd_data !== 24'd0) begin
            miscompares++;
            $display("FAIL first_pop empty=%b count=%0d rd=%h, want 1 0 000000", empty, count, rd_data);
        end
    endtask

    task automatic test_delta();
        do_clear();
        push(8'h01);
        repeat (2) tick();
        push(8'h02);
        repeat (69999) tick();
        push(8'h03);
        vectors++;
        if (count !== 5'd3) begin
            miscompares++;
            $display("FAIL delta_count got %0d want 3", count);
        end
        vectors++;
        if (rd_data !== {16'd0, 8'h01}) begin
            miscompares++;
            $display("FAIL delta_e1 got %h want %h", rd_data, {16'd0, 8'h01});
        end
        pop();
        vectors++;
        if (rd_data !== {16'd3, 8'h02}) begin
            miscompares++;
            $display("FAIL delta_e2 got %h want %h", rd_data, {16'd3, 8'h02});
        end
        pop();
        vectors++;
        if (rd_data !== {16'hFFFF, 8'h03}) begin
            miscompares++;
            $display("FAIL delta_sat got %h want %h", rd_data, {16'hFFFF, 8'h03});
        end
        pop();
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL delta_drain empty=%b want 1", empty);
        end
    endtask

    task automatic test_overflow();
        logic [23:0] exp;
        do_clear();
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i));
        vectors++;
        if (full !== 1'b1 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL ovf_full full=%b count=%0d, want 1 16", full, count);
        end
        vectors++;
        if (overflow !== 1'b1 || drop_count !== 8'd3 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_flags ovf=%b drop=%0d unf=%b, want 1 3 0", overflow, drop_count, underflow);
        end
        for (int i = 0; i < 16; i++) begin
            exp = {(i == 0) ? 16'd0 : 16'd1, 8'h10 + 8'(i)};
            vectors++;
            if (rd_data !== exp) begin
                miscompares++;
                $display("FAIL ovf_order[%0d] got %h want %h", i, rd_data, exp);
            end
            pop();
        end
        vectors++;
        if (empty !== 1'b1 || overflow !== 1'b1 || drop_count !== 8'd3) begin
            miscompares++;
            $display("FAIL ovf_sticky empty=%b ovf=%b drop=%0d, want 1 1 3", empty, overflow, drop_count);
        end
    endtask

    task automatic test_full_rw();
        do_clear();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        in_pulse = 1'b1;
        in_data  = 8'h99;
        rd_en    = 1'b1;
        tick();
        in_pulse = 1'b0;
        rd_en    = 1'b0;
        vectors++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL full_rw_status count=%0d full=%b ovf=%b drop=%0d, want 16 1 0 0",
                     count, full, overflow, drop_count);
        end
        vectors++;
        if (rd_data !== {16'd1, 8'h21}) begin
            miscompares++;
            $display("FAIL full_rw_head got %h want %h", rd_data, {16'd1, 8'h21});
        end
        repeat (15) pop();
        vectors++;
        if (rd_data !== {16'd1, 8'h99} || count !== 5'd1) begin
            miscompares++;
            $display("FAIL full_rw_tail got %h count=%0d want %h 1", rd_data, count, {16'd1, 8'h99});
        end
        pop();
    endtask

    task automatic test_underflow();
        do_clear();
        pop();
        vectors++;
        if (underflow !== 1'b1 || count !== 5'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL unf_alone unf=%b count=%0d empty=%b, want 1 0 1", underflow, count, empty);
        end
        do_clear();
        in_pulse = 1'b1;
        in_data  = 8'h5A;
        rd_en    = 1'b1;
        tick();
        in_pulse = 1'b0;
        rd_en    = 1'b0;
        vectors++;
        if (underflow !== 1'b1 || count !== 5'd1 || rd_data !== {16'd0, 8'h5A}) begin
            miscompares++;
            $display("FAIL unf_with_wr unf=%b count=%0d rd=%h, want 1 1 %h",
                     underflow, count, rd_data, {16'd0, 8'h5A});
        end
    endtask

    task automatic test_clear_prio();
        do_clear();
        pop();
        for (int i = 0; i < 9; i++) push(8'h40 + 8'(i));
        vectors++;
        if (count !== 5'd9 || underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_setup count=%0d unf=%b, want 9 1", count, underflow);
        end
        clear_i  = 1'b1;
        in_pulse = 1'b1;
        in_data  = 8'hCC;
        rd_en    = 1'b1;
        tick();
        clear_i  = 1'b0;
        in_pulse = 1'b0;
        rd_en    = 1'b0;
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_data !== 24'd0) begin
            miscompares++;
            $display("FAIL clr_status count=%0d empty=%b full=%b rd=%h, want 0 1 0 000000",
                     count, empty, full, rd_data);
        end
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL clr_flags ovf=%b unf=%b drop=%0d, want 0 0 0", overflow, underflow, drop_count);
        end
        tick();
        push(8'h77);
        vectors++;
        if (rd_data !== {16'd1, 8'h77}) begin
            miscompares++;
            $display("FAIL clr_delta got %h want %h", rd_data, {16'd1, 8'h77});
        end
    endtask

    task automatic test_async_reset();
        push(8'h81);
        push(8'h82);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0 || rd_data !== 24'd0) begin
            miscompares++;
            $display("FAIL async_rst empty=%b count=%0d rd=%h, want 1 0 000000", empty, count, rd_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL async_rst_after empty=%b count=%0d, want 1 0", empty, count);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b1;
        clear_i     = 1'b0;
        in_pulse    = 1'b0;
        in_data     = 8'h00;
        rd_en       = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_word();
        test_delta();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_clear_prio();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
